// File: rtl/tdm_mux_tx_pkg.sv
// Shared types and constants for the TDM transmit block.
package tdm_pkg;

  localparam int DEF_SEL_W       = 3;
  localparam int DEF_SLOT_CYCLES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    PAR  = 2'd2
  } tdm_state_t;

  // A single-cycle slot still needs a 1-bit counter.
  function automatic int slot_cnt_w(input int slot_cycles);
    return (slot_cycles > 1) ? $clog2(slot_cycles) : 1;
  endfunction

endpackage

// File: rtl/tdm_mux_tx_if.sv
// Parallel word handshake into the TDM transmitter.
interface tdm_mux_tx_if #(
  parameter int NUM_CH = 8
);
  logic [NUM_CH-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/tdm_slot_timer.sv
// Slot and channel counters for one TDM frame; both freeze while run is low.
module tdm_slot_timer
  import tdm_pkg::*;
#(
  parameter int SEL_W       = DEF_SEL_W,
  parameter int SLOT_CYCLES = DEF_SLOT_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             run,
  output logic [SEL_W-1:0] ch_cnt,
  output logic [SEL_W-1:0] ch_nxt,
  output logic             slot_last,
  output logic             frame_last
);
  localparam int               SW       = slot_cnt_w(SLOT_CYCLES);
  localparam logic [SW-1:0]    SLOT_MAX = SW'(SLOT_CYCLES - 1);
  localparam logic [SEL_W-1:0] CH_MAX   = '1;

  logic [SW-1:0]    slot_reg, slot_next;
  logic [SEL_W-1:0] ch_reg, ch_next;

  assign slot_last  = (slot_reg == SLOT_MAX);
  assign frame_last = slot_last && (ch_reg == CH_MAX);
  assign ch_cnt     = ch_reg;
  assign ch_nxt     = ch_next;

  // The channel saturates at the last code so a trailing parity slot keeps sel there.
  always_comb begin
    slot_next = slot_reg;
    ch_next   = ch_reg;
    if (clr) begin
      slot_next = '0;
      ch_next   = '0;
    end else if (run) begin
      if (slot_last) begin
        slot_next = '0;
        if (ch_reg != CH_MAX) ch_next = ch_reg + 1'b1;
      end else begin
        slot_next = slot_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_reg <= '0;
      ch_reg   <= '0;
    end else begin
      slot_reg <= slot_next;
      ch_reg   <= ch_next;
    end
  end

endmodule

// File: rtl/tdm_mux_tx.sv
// 8:1 TDM transmitter: captures a parallel word, serialises it with matching select code.
// Define TDM_PARITY_EN to append an even-parity slot after the last channel.
module tdm_mux_tx
  import tdm_pkg::*;
#(
  parameter int SEL_W       = DEF_SEL_W,
  parameter int SLOT_CYCLES = DEF_SLOT_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  tdm_mux_tx_if.slave      in_if,
  input  logic             en,
  output logic             out,
  output logic [SEL_W-1:0] sel,
  output logic             frame_start,
  output logic             busy,
  output logic             done
`ifdef TDM_PARITY_EN
  ,
  output logic             par_slot
`endif
);
  localparam int NUM_CH = 2 ** SEL_W;

  tdm_state_t        state_reg;
  logic [NUM_CH-1:0] cap_reg;
  logic              out_reg;
  logic              frame_start_reg;
  logic              busy_reg;
  logic              rdy_reg;

  logic [SEL_W-1:0]  ch_cnt, ch_nxt;
  logic              slot_last, frame_last;
  logic              accept, frame_end, timer_clr, timer_run;

  assign accept = in_if.in_valid & in_if.in_ready;

  // done depends on en so a frozen final cycle neither pulses nor opens the accept window.
`ifdef TDM_PARITY_EN
  assign frame_end = (state_reg == PAR) & slot_last & en;
  assign par_slot  = (state_reg == PAR);
`else
  assign frame_end = (state_reg == SEND) & frame_last & en;
`endif

  assign in_if.in_ready = rdy_reg | frame_end;
  assign timer_clr      = (state_reg == IDLE) | frame_end;
  assign timer_run      = (state_reg != IDLE) & en;

  assign out         = out_reg;
  assign sel         = ch_cnt;
  assign frame_start = frame_start_reg;
  assign busy        = busy_reg;
  assign done        = frame_end;

  tdm_slot_timer #(
    .SEL_W      (SEL_W),
    .SLOT_CYCLES(SLOT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (timer_clr),
    .run       (timer_run),
    .ch_cnt    (ch_cnt),
    .ch_nxt    (ch_nxt),
    .slot_last (slot_last),
    .frame_last(frame_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      cap_reg         <= '0;
      out_reg         <= 1'b0;
      frame_start_reg <= 1'b0;
      busy_reg        <= 1'b0;
      rdy_reg         <= 1'b0;
    end else begin
      frame_start_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          rdy_reg  <= 1'b1;
          out_reg  <= 1'b0;
          busy_reg <= 1'b0;
          if (accept) begin
            state_reg       <= SEND;
            cap_reg         <= in_if.in_data;
            out_reg         <= in_if.in_data[0];
            frame_start_reg <= 1'b1;
            busy_reg        <= 1'b1;
            rdy_reg         <= 1'b0;
          end
        end
        SEND, PAR: begin
          if (frame_end) begin
            if (accept) begin
              // Back-to-back word: channel 0 follows with no idle gap.
              state_reg       <= SEND;
              cap_reg         <= in_if.in_data;
              out_reg         <= in_if.in_data[0];
              frame_start_reg <= 1'b1;
            end else begin
              state_reg <= IDLE;
              out_reg   <= 1'b0;
              busy_reg  <= 1'b0;
              rdy_reg   <= 1'b1;
            end
`ifdef TDM_PARITY_EN
          end else if (en && frame_last && state_reg == SEND) begin
            state_reg <= PAR;
            out_reg   <= ^cap_reg;
`endif
          end else if (en && slot_last && state_reg == SEND) begin
            out_reg <= cap_reg[ch_nxt];
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_mux_tx.sv
// Directed bench for tdm_mux_tx (SLOT_CYCLES=4) plus a SLOT_CYCLES=1 instance.
module tb_tdm_mux_tx;
  localparam int NUM_CH = 8;
  localparam int SLOT   = 4;
`ifdef TDM_PARITY_EN
  localparam bit HAS_PAR = 1'b1;
`else
  localparam bit HAS_PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       out, frame_start, busy, done;
  logic [2:0] sel;
  logic       out1, frame_start1, busy1, done1;
  logic [2:0] sel1;
`ifdef TDM_PARITY_EN
  logic       par_slot, par_slot1;
`endif

  int vecs = 0;
  int miscompares = 0;

  tdm_mux_tx_if #(.NUM_CH(NUM_CH)) bus ();
  tdm_mux_tx_if #(.NUM_CH(NUM_CH)) bus1 ();

  tdm_mux_tx #(.SEL_W(3), .SLOT_CYCLES(SLOT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_if      (bus),
    .en         (en),
    .out        (out),
    .sel        (sel),
    .frame_start(frame_start),
    .busy       (busy),
    .done       (done)
`ifdef TDM_PARITY_EN
    ,
    .par_slot   (par_slot)
`endif
  );

  tdm_mux_tx #(.SEL_W(3), .SLOT_CYCLES(1)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_if      (bus1),
    .en         (en),
    .out        (out1),
    .sel        (sel1),
    .frame_start(frame_start1),
    .busy       (busy1),
    .done       (done1)
`ifdef TDM_PARITY_EN
    ,
    .par_slot   (par_slot1)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_word(input logic [7:0] w);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    en = 1'b1;
    #1;
    chk("accept_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
  endtask

  task automatic idle_check(input string tag);
    bus.in_valid = 1'b0;
    en = 1'b1;
    #1;
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_sel"}, 32'(sel), 32'd0);
    chk({tag, "_out"}, 32'(out), 32'd0);
    chk({tag, "_fs"}, 32'(frame_start), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    @(negedge clk);
  endtask

  // Walks one frame cycle by cycle; optionally freezes en at slot 1 of pause_ch.
  task automatic run_frame(input logic [7:0] bits, input int pause_ch, input int pause_len,
                           input bit b2b, input logic [7:0] nxt);
    int  ch, slot, paused, total;
    bit  par_mode, last, en_now;
    ch = 0; slot = 0; paused = 0; par_mode = 1'b0;
    total = NUM_CH * SLOT + pause_len + (HAS_PAR ? SLOT : 0);
    for (int k = 1; k <= total; k++) begin
      en_now = !(ch == pause_ch && slot == 1 && paused < pause_len);
      last   = par_mode ? (slot == SLOT - 1)
                        : (!HAS_PAR && ch == NUM_CH - 1 && slot == SLOT - 1);
      en = en_now;
      bus.in_valid = b2b;
      bus.in_data  = nxt;
      #1;
      chk($sformatf("sel@%0d", k), 32'(sel), par_mode ? 32'(NUM_CH - 1) : 32'(ch));
      chk($sformatf("out@%0d", k), 32'(out), par_mode ? 32'(^bits) : 32'(bits[ch]));
      chk($sformatf("busy@%0d", k), 32'(busy), 32'd1);
      chk($sformatf("frame_start@%0d", k), 32'(frame_start), 32'(k == 1));
      chk($sformatf("done@%0d", k), 32'(done), 32'(last && en_now));
      chk($sformatf("in_ready@%0d", k), 32'(bus.in_ready), 32'(last && en_now));
`ifdef TDM_PARITY_EN
      chk($sformatf("par_slot@%0d", k), 32'(par_slot), 32'(par_mode));
`endif
      if (en_now) begin
        if (slot == SLOT - 1) begin
          slot = 0;
          if (ch == NUM_CH - 1) par_mode = 1'b1;
          else ch++;
        end else begin
          slot++;
        end
      end else begin
        paused++;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] w1;
    // Reset held with a valid word pending: nothing may be accepted.
    rst_n = 1'b0; en = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = 8'hFF;
    bus1.in_valid = 1'b0; bus1.in_data = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_fs", 32'(frame_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk("post_rst_ready", 32'(bus.in_ready), 32'd1);
    chk("post_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);

    // Single frame; in_data is scrambled while busy and must be ignored.
    start_word(8'b1010_0110);
    run_frame(8'b1010_0110, -1, 0, 1'b0, 8'h5A);
    idle_check("single_idle");

    // Back-to-back frames with no gap.
    start_word(8'h0F);
    run_frame(8'h0F, -1, 0, 1'b1, 8'hF0);
    run_frame(8'hF0, -1, 0, 1'b0, 8'h00);
    idle_check("b2b_idle");

    // en low for 5 cycles inside channel 3.
    start_word(8'h08);
    run_frame(8'h08, 3, 5, 1'b0, 8'h00);
    idle_check("pause_idle");

    // Odd-weight word: parity slot (when built in) drives 1.
    start_word(8'h07);
    run_frame(8'h07, -1, 0, 1'b0, 8'h00);
    idle_check("par_idle");

    // Asynchronous reset at channel 5.
    start_word(8'h20);
    bus.in_valid = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    chk("mid_sel", 32'(sel), 32'd5);
    chk("mid_out", 32'(out), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out", 32'(out), 32'd0);
    chk("mid_rst_sel", 32'(sel), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    idle_check("mid_rst_idle");

    // SLOT_CYCLES=1: one cycle per channel, done on channel 7.
    w1 = 8'hC3;
    bus1.in_valid = 1'b1; bus1.in_data = w1;
    #1;
    chk("s1_ready", 32'(bus1.in_ready), 32'd1);
    @(negedge clk);
    bus1.in_valid = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      #1;
      chk($sformatf("s1_sel@%0d", k), 32'(sel1), 32'(k));
      chk($sformatf("s1_out@%0d", k), 32'(out1), 32'(w1[k]));
      chk($sformatf("s1_fs@%0d", k), 32'(frame_start1), 32'(k == 0));
      chk($sformatf("s1_done@%0d", k), 32'(done1), 32'(k == NUM_CH - 1 && !HAS_PAR));
      @(negedge clk);
    end
`ifdef TDM_PARITY_EN
    #1;
    chk("s1_par_out", 32'(out1), 32'(^w1));
    chk("s1_par_done", 32'(done1), 32'd1);
    @(negedge clk);
`endif
    #1;
    chk("s1_idle_busy", 32'(busy1), 32'd0);
    chk("s1_idle_ready", 32'(bus1.in_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
